// File: rtl/dhash_pkg.sv
// rtl/dhash_pkg.sv - shared encodings for the dHash motion controller
package dhash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READ    = 3'd3,
        ST_DECIDE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_STATUS    = 3'd0;
    localparam logic [2:0] OP_CONTROL   = 3'd1;
    localparam logic [2:0] OP_THRESHOLD = 3'd2;
    localparam logic [2:0] OP_DISTANCE  = 3'd3;
    localparam logic [2:0] OP_CLEAR     = 3'd4;
    localparam logic [2:0] OP_NOP       = 3'd5;

    // Bit positions shared by the control write and the status word
    localparam int STAT_ENABLE     = 0;
    localparam int STAT_CONTINUOUS = 1;
    localparam int STAT_IRQ_ENABLE = 2;
    localparam int STAT_MOTION     = 3;
    localparam int STAT_PREV_VALID = 4;
    localparam int STAT_STATE_LSB  = 5;

    localparam int SIG_WORDS = 4;

    function automatic logic [31:0] pack_status(
        input logic [2:0] st,
        input logic       prev_valid,
        input logic       motion,
        input logic       irq_enable,
        input logic       continuous,
        input logic       enable
    );
        return {24'd0, st, prev_valid, motion, irq_enable, continuous, enable};
    endfunction

endpackage

// File: rtl/popcount32.sv
// rtl/popcount32.sv - combinational 32-bit population count
module popcount32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Plain adder chain; synthesis rebalances it into a tree
    always_comb begin
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + 6'(value[i]);
        end
    end

endmodule

// File: rtl/dhash_motion_ctrl.sv
// rtl/dhash_motion_ctrl.sv - frame signature capture, compare and motion flag
module dhash_motion_ctrl
    import dhash_pkg::*;
#(
    parameter logic [7:0] customId         = 8'd0,
    parameter logic [7:0] defaultThreshold = 8'd10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsyncPulse,
    input  logic        ciStart,
    input  logic [7:0]  ciN,
    input  logic [31:0] ciValueA,
    input  logic [31:0] ciValueB,
    output logic [31:0] ciResult,
    output logic        ciDone,
    output logic        takeSignature,
    output logic [1:0]  sigAddress,
    input  logic [31:0] sigData,
    output logic        motionIrq
);

    state_t       state;
    state_t       next_state;
    logic         enable;
    logic         continuous;
    logic         irq_enable;
    logic [7:0]   threshold;
    logic [127:0] prev_sig;
    logic [127:0] new_sig;
    logic         prev_valid;
    logic [7:0]   distance;
    logic         motion_flag;
    logic [15:0]  frame_count;
    logic [2:0]   read_count;

    logic         accept;
    logic [2:0]   op;
    logic         disable_write;
    logic [1:0]   word_idx;
    logic [31:0]  prev_word;
    logic [5:0]   word_ones;
    logic         unused_bits;

    assign accept        = ciStart && (ciN == customId);
    assign op            = ciValueA[2:0];
    assign disable_write = accept && (op == OP_CONTROL) && !ciValueB[STAT_ENABLE];
    assign unused_bits   = ^{ciValueA[31:3], ciValueB[31:8]};

    // Data returned in READ cycle k belongs to the address driven in cycle k-1
    assign word_idx  = 2'(read_count - 3'd1);
    assign prev_word = prev_sig[{word_idx, 5'd0} +: 32];

    popcount32 u_popcount (
        .value (sigData ^ prev_word),
        .count (word_ones)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a disable write overrides every state
    always_comb begin
        next_state = state;
        if (disable_write) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (enable) next_state = ST_ARM;
                ST_ARM:     if (vsyncPulse) next_state = ST_CAPTURE;
                ST_CAPTURE: if (vsyncPulse) next_state = ST_READ;
                ST_READ:    if (read_count == 3'(SIG_WORDS)) next_state = ST_DECIDE;
                ST_DECIDE:  next_state = continuous ? ST_ARM : ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state so reset drops them without a clock
    always_comb begin
        takeSignature = (state == ST_CAPTURE);
        sigAddress    = 2'd0;
        if (state == ST_READ && read_count < 3'(SIG_WORDS)) begin
            sigAddress = read_count[1:0];
        end
        motionIrq = motion_flag && irq_enable;
    end

    // Control and threshold registers; a CPU write wins over the one-shot enable clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable     <= 1'b0;
            continuous <= 1'b0;
            irq_enable <= 1'b0;
            threshold  <= defaultThreshold;
        end else begin
            if (state == ST_DECIDE && !continuous) begin
                enable <= 1'b0;
            end
            if (accept && op == OP_CONTROL) begin
                enable     <= ciValueB[STAT_ENABLE];
                continuous <= ciValueB[STAT_CONTINUOUS];
                irq_enable <= ciValueB[STAT_IRQ_ENABLE];
            end
            if (accept && op == OP_THRESHOLD) begin
                threshold <= ciValueB[7:0];
            end
        end
    end

    // Signature readback, distance accumulation and frame bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_count  <= 3'd0;
            distance    <= 8'd0;
            new_sig     <= '0;
            prev_sig    <= '0;
            prev_valid  <= 1'b0;
            frame_count <= 16'd0;
        end else if (disable_write) begin
            read_count <= 3'd0;
            prev_valid <= 1'b0;
        end else begin
            case (state)
                ST_CAPTURE: begin
                    if (vsyncPulse) begin
                        read_count <= 3'd0;
                        distance   <= 8'd0;
                    end
                end
                ST_READ: begin
                    read_count <= read_count + 3'd1;
                    if (read_count != 3'd0) begin
                        distance                        <= distance + {2'd0, word_ones};
                        new_sig[{word_idx, 5'd0} +: 32] <= sigData;
                    end
                end
                ST_DECIDE: begin
                    prev_sig    <= new_sig;
                    prev_valid  <= 1'b1;
                    frame_count <= frame_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Motion flag: a set in DECIDE beats a same-cycle clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            motion_flag <= 1'b0;
        end else if (state == ST_DECIDE && !disable_write && prev_valid && distance > threshold) begin
            motion_flag <= 1'b1;
        end else if (accept && op == OP_CLEAR) begin
            motion_flag <= 1'b0;
        end
    end

    // Custom-instruction response, registered one cycle after acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ciDone   <= 1'b0;
            ciResult <= 32'd0;
        end else if (accept) begin
            ciDone <= 1'b1;
            case (op)
                OP_STATUS:   ciResult <= pack_status(state, prev_valid, motion_flag,
                                                     irq_enable, continuous, enable);
                OP_DISTANCE: ciResult <= {frame_count, 8'd0, distance};
                default:     ciResult <= 32'd0;
            endcase
        end else begin
            ciDone   <= 1'b0;
            ciResult <= 32'd0;
        end
    end

endmodule

// File: doc/dhash_motion_ctrl.md
Name: dhash_motion_ctrl

Overview:
- Sequences the dHash signature datapath from the CPU clock domain: arms signature capture for one frame, reads back the four 32-bit signature words, and compares them with the previous frame's 128-bit signature.
- Computes the Hamming distance between the two signatures and raises a motion flag and interrupt when the distance exceeds a programmable threshold.
- Configured and polled through the custom-instruction interface. Sits between the CPU custom-instruction bus and the dHash signature buffer read port.

Parameters:
- customId, 8'd0, custom-instruction number this block answers to.
- defaultThreshold, 8'd10, reset value of the motion threshold register.

Ports:
- clock  in  1  system clock; the only clock of the block.
- reset  in  1  asynchronous, active-high reset.
- vsyncPulse  in  1  single-cycle start-of-frame pulse, already synchronised to clock.
- ciStart  in  1  custom-instruction start.
- ciN  in  8  custom-instruction number.
- ciValueA  in  32  [2:0] = operation select.
- ciValueB  in  32  write data.
- ciResult  out  32  read data; 0 unless ciDone and ciN == customId.
- ciDone  out  1  one-cycle completion pulse.
- takeSignature  out  1  enables signature-buffer writes in the datapath.
- sigAddress  out  2  signature-buffer read address.
- sigData  in  32  signature-buffer read data; 1-cycle read latency.
- motionIrq  out  1  level interrupt; equals motionFlag AND irqEnable.

Behaviour:
- Reset values:
  - outputs: all 0.
  - state = IDLE; threshold = defaultThreshold.
  - prevSig = 0; prevValid = 0; distance = 0; motionFlag = 0; frameCount = 0; control bits = 0.
- Custom instruction:
  - Accepted when ciStart = 1 and ciN == customId.
  - ciDone pulses exactly 1 cycle later; ciResult is registered with it.
- Operations (ciValueA[2:0]):
  - 0 = read status {24'b0, state[2:0], prevValid, motionFlag, irqEnable, continuous, enable}.
  - 1 = write control: ciValueB[0] enable, [1] continuous, [2] irqEnable.
  - 2 = write threshold: ciValueB[7:0].
  - 3 = read {frameCount[15:0], 8'b0, distance[7:0]}.
  - 4 = clear motionFlag.
  - 5-7 = no-op; return 0.
  - Writes return 0.
- FSM states:
  - IDLE: takeSignature = 0. Go to ARM when enable = 1.
  - ARM: wait for vsyncPulse. On the pulse, set takeSignature = 1 and go to CAPTURE.
  - CAPTURE: hold takeSignature = 1 for the whole frame. On the next vsyncPulse, set takeSignature = 0 and go to READ.
  - READ: drive sigAddress 0,1,2,3 on consecutive cycles. Data for address k arrives at cycle k+1. Per word, accumulate popcount(sigData XOR prevSig word k) into distance (8-bit; maximum 128, never wraps) and latch the word into newSig. Lasts 5 cycles, then go to DECIDE.
  - DECIDE (1 cycle):
    - If prevValid and distance > threshold (strict), set motionFlag.
    - Copy newSig to prevSig; set prevValid = 1; frameCount += 1 (wraps at 16 bits).
    - Next state: ARM if continuous, else IDLE with enable cleared.
- Clear the distance accumulator on entry to READ. distance holds its last value until the next READ.
- vsyncPulse is ignored in IDLE, READ and DECIDE; that frame is skipped.
- Writing enable = 0:
  - From any state: go to IDLE next cycle, takeSignature = 0, prevValid = 0. motionFlag is retained.
  - An enable = 0 write during READ aborts the read. prevSig is not updated.
- Simultaneous clear (op 4) and set in DECIDE: set wins.
- A threshold write takes effect at the next DECIDE.
- The first comparison after enable never sets motionFlag, because prevValid = 0.
- Asynchronous reset mid-frame: takeSignature drops immediately.

Decomposition:
- Shared package (dhash_pkg):
  - FSM state encoding (IDLE=0, ARM=1, CAPTURE=2, READ=3, DECIDE=4).
  - Op codes 0-5.
  - Status bit positions.
  - SIG_WORDS = 4.
- Sub-module popcount32: combinational 32-bit population count to 6 bits, reused by other signature comparators.

Test Plan:
- Reset then op0 read -> ciResult = 0x0, ciDone 1 cycle after ciStart, takeSignature = 0, threshold readback via decision = 10.
- enable + continuous; two vsync pulses; sigData all 0xFFFFFFFF -> takeSignature high exactly between the pulses, sigAddress 0..3 sequenced, distance = 128, motionFlag = 0 (prevValid was 0), frameCount = 1.
- Second frame, words 0x0000000F, 0, 0, 0 versus previous all-ones -> distance = 124 > 10, motionFlag = 1, motionIrq = 1 only if irqEnable.
- Threshold = 4, next frame differs by exactly 4 bits -> motionFlag stays 0; differs by 5 bits -> motionFlag = 1; op4 clear in the same cycle as DECIDE -> flag remains 1.
- vsyncPulse during READ -> ignored, READ completes in 5 cycles, frameCount increments by 1 only.
- enable = 0 written during CAPTURE -> next cycle state = IDLE, takeSignature = 0, prevValid = 0; asynchronous reset in CAPTURE -> all outputs 0 immediately.
